icache_arbiter: RTL and testbench
=================================

Name: icache_arbiter

Overview:
- Shares the single-port, read-only 256x16 instruction cache between two requesters: port 0 (core fetch) and port 1 (debug/loader read-back).
- Accepts requests through valid/ready handshakes and issues one cache read at a time.
- Captures the 1-cycle-latency read data and returns it on a per-port response handshake with backpressure.
- Sits between the fetch stage / debug unit and the icache memory.

Parameters:
- ADDR_W, 16, request and memory address width.
- DATA_W, 16, instruction word width.
- DEPTH_LOG2, 8, log2 of the implemented cache words. Addresses at or above 2**DEPTH_LOG2 are out of range.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid (bit 0 = fetch, bit 1 = debug).
- req_addr0  in  ADDR_W  port 0 word address.
- req_addr1  in  ADDR_W  port 1 word address.
- req_ready  out  2  per-port request accept; combinational, one-hot or zero.
- rsp_valid  out  2  per-port response valid; registered, one-hot or zero.
- rsp_ready  in  2  per-port response accept.
- rsp_data  out  DATA_W  response word; shared bus, qualified by rsp_valid.
- rsp_err  out  1  response is an out-of-range error; qualified by rsp_valid.
- mem_r_en  out  1  cache read enable.
- mem_addr  out  ADDR_W  cache read address.
- mem_data  in  DATA_W  cache read data, valid the cycle after mem_r_en.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, rr_ptr=0, owner=0. mem_r_en=0 and req_ready=0 while reset is high.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any req_valid bit is set, the arbiter picks a winner and drives req_ready[winner]=1 in that cycle, then latches owner=winner.
  - In-range address: mem_r_en=1, mem_addr=winner address, next state WAIT.
  - Out-of-range address (addr >> DEPTH_LOG2 != 0): mem_r_en=0, rsp_data<=0, rsp_err<=1, next state RESP.
  - With no request: stay in IDLE, mem_r_en=0.
- WAIT: rsp_data<=mem_data, rsp_err<=0, rsp_valid[owner]<=1, next state RESP. No request is accepted in WAIT.
- RESP:
  - rsp_valid[owner] and rsp_data are held stable until rsp_ready[owner]=1.
  - On that handshake, rsp_valid clears next cycle and the state returns to IDLE.
  - rsp_ready on the non-owner port is ignored. No request is accepted in RESP.
- Latency and throughput: request accepted at cycle T gives rsp_valid at T+2 with rsp_ready held high (error path: T+1). Maximum throughput is one request per 3 cycles.
- Arbitration:
  - Round-robin over the 2 ports; rr_ptr names the preferred port.
  - On each grant, rr_ptr <= ~winner.
  - Single requester always wins regardless of rr_ptr.
- Request stability: a requester holds req_valid and its address until ready. The arbiter samples the address only in the grant cycle.
- mem_addr is 0 whenever mem_r_en=0.
- Reset mid-operation: an in-flight read or pending response is dropped, with no rsp_valid after reset. The requester must reissue.
- Simultaneous grant and rsp_ready on the same port cannot occur (different states).

Optional Feature:
- ICACHE_ARB_FIXED_PRIO_EN defined: fixed priority, port 0 (fetch) always beats port 1. rr_ptr is not implemented.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_WAIT=2'd1, ST_RESP=2'd2) and port index constants (PORT_FETCH=0, PORT_DBG=1).
- Sub-module rr_arbiter2: combinational 2-way grant from req and rr_ptr. Under ICACHE_ARB_FIXED_PRIO_EN it reduces to a priority encoder.

Test Plan:
- Reset, then req_valid=01, addr0=0x0005, rsp_ready=01 held -> req_ready=01 at T; mem_r_en=1, mem_addr=0x0005 at T; rsp_valid=01, rsp_data=0x0005 (init contents), rsp_err=0 at T+2.
- req_valid=11 held continuously, rsp_ready=11 -> grants alternate 01,10,01,10 every 3 cycles. With ICACHE_ARB_FIXED_PRIO_EN, all grants go to port 0.
- Port 1 addr=0x0100 -> no mem_r_en; rsp_valid=10, rsp_data=0, rsp_err=1 at T+1.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data held stable, req_ready=00 throughout; release gives one handshake then IDLE.
- Reset asserted during WAIT -> next cycle rsp_valid=00, state IDLE; no stale response appears afterwards.
- Non-owner rsp_ready=1 while owner rsp_ready=0 -> response remains pending.

Source files
------------

// File: rtl/icache_arbiter_pkg.sv
// Shared state encoding and port indices for the icache arbiter.
// Optional build macro: ICACHE_ARB_FIXED_PRIO_EN (see icache_arbiter.sv).
package icache_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int PORT_FETCH = 0;
    localparam int PORT_DBG   = 1;

    function automatic logic [1:0] port_onehot(input logic p);
        port_onehot = p ? (2'b01 << PORT_DBG) : (2'b01 << PORT_FETCH);
    endfunction

endpackage

// File: rtl/icache_arbiter_rr_arbiter2.sv
// Combinational 2-way grant; round-robin by default.
// ICACHE_ARB_FIXED_PRIO_EN turns it into a fetch-first priority encoder.
module icache_arbiter_rr_arbiter2 (
`ifndef ICACHE_ARB_FIXED_PRIO_EN
    input  logic       rr_ptr,
`endif
    input  logic [1:0] req,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
`ifdef ICACHE_ARB_FIXED_PRIO_EN
        if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
`else
        // rr_ptr only matters on a tie
        if (&req) begin
            grant = rr_ptr ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
`endif
    end

endmodule

// File: rtl/icache_arbiter.sv
// Two-port arbiter in front of the single-port read-only icache.
// Define ICACHE_ARB_FIXED_PRIO_EN for fixed fetch-first priority.
module icache_arbiter
    import icache_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data
);

    state_e            r_state;
    state_e            w_next;
    logic              r_owner;
    logic [1:0]        r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
`ifndef ICACHE_ARB_FIXED_PRIO_EN
    logic              r_rr_ptr;
`endif

    logic [1:0]        w_grant;
    logic              w_idle;
    logic              w_take;
    logic              w_win;
    logic              w_oor;
    logic [ADDR_W-1:0] w_addr;

    icache_arbiter_rr_arbiter2 u_arb (
`ifndef ICACHE_ARB_FIXED_PRIO_EN
        .rr_ptr (r_rr_ptr),
`endif
        .req    (req_valid),
        .grant  (w_grant)
    );

    always_comb begin
        w_idle    = (r_state == ST_IDLE) && !reset;
        w_take    = w_idle && (|req_valid);
        w_win     = w_grant[1];
        w_addr    = w_win ? req_addr1 : req_addr0;
        w_oor     = |(w_addr >> DEPTH_LOG2);
        req_ready = w_idle ? w_grant : 2'b00;
        mem_r_en  = w_take && !w_oor;
        mem_addr  = mem_r_en ? w_addr : '0;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_next = w_oor ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: w_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready[r_owner]) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner     <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
`ifndef ICACHE_ARB_FIXED_PRIO_EN
            r_rr_ptr    <= 1'b0;
`endif
        end else begin
            if (w_take) begin
                r_owner <= w_win;
`ifndef ICACHE_ARB_FIXED_PRIO_EN
                r_rr_ptr <= ~w_win;
`endif
                // out-of-range skips the cache and answers next cycle
                if (w_oor) begin
                    r_rsp_data  <= '0;
                    r_rsp_err   <= 1'b1;
                    r_rsp_valid <= port_onehot(w_win);
                end
            end
            if (r_state == ST_WAIT) begin
                r_rsp_data  <= mem_data;
                r_rsp_err   <= 1'b0;
                r_rsp_valid <= port_onehot(r_owner);
            end
            if (r_state == ST_RESP && rsp_ready[r_owner]) begin
                r_rsp_valid <= 2'b00;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_icache_arbiter.sv
// Randomized bench for icache_arbiter against a transaction-level model.
module tb_icache_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [15:0] req_addr0 = '0;
    logic [15:0] req_addr1 = '0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        mem_r_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_data = '0;

    logic [15:0] mem [256];

    int vectors = 0;
    int miscompares = 0;

    bit          hv [2];
    logic [15:0] ha [2];
    logic [1:0]  rdy;
    bit          rst;
    int          mode;

    // transaction model: at most one outstanding read
    bit          m_busy;
    int          m_port;
    logic [15:0] m_data;
    bit          m_err;
    int          m_due;
    int          m_pref;
    int          cyc;

    icache_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr0 (req_addr0),
        .req_addr1 (req_addr1),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mem_r_en  (mem_r_en),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_r_en) mem_data <= mem[mem_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 16'h0100 + 16'($urandom_range(0, 16'hFEFF));
        if (r == 1) return 16'h00FF;
        return 16'($urandom_range(0, 255));
    endfunction

    task automatic cycle();
        int win;
        logic [15:0] a;
        @(posedge clk);
        cyc++;
        #1;
        for (int p = 0; p < 2; p++) begin
            if (!hv[p]) begin
                if (mode == 1) begin
                    hv[p] = 1'b1;
                    ha[p] = 16'($urandom_range(0, 255));
                end else if (mode == 2 && $urandom_range(0, 2) == 0) begin
                    hv[p] = 1'b1;
                    ha[p] = rand_addr();
                end
            end
        end
        if (mode == 2) rdy = 2'($urandom);
        reset     = rst;
        req_valid = {hv[1], hv[0]};
        req_addr0 = ha[0];
        req_addr1 = ha[1];
        rsp_ready = rdy;
        @(negedge clk);
        if (rst) begin
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_mem_r_en", 32'(mem_r_en), 32'd0);
            m_busy = 1'b0;
            m_pref = 0;
        end else if (!m_busy) begin
            check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            win = -1;
            if (hv[0] && hv[1]) begin
`ifdef ICACHE_ARB_FIXED_PRIO_EN
                win = 0;
`else
                win = m_pref;
`endif
            end else if (hv[0]) begin
                win = 0;
            end else if (hv[1]) begin
                win = 1;
            end
            check("req_ready", 32'(req_ready),
                  (win < 0) ? 32'd0 : (32'd1 << win));
            if (win >= 0) begin
                a = ha[win];
                m_busy = 1'b1;
                m_port = win;
                m_err  = (a > 16'd255);
                m_data = m_err ? 16'h0 : mem[a[7:0]];
                m_due  = cyc + (m_err ? 1 : 2);
                m_pref = 1 - win;
                hv[win] = 1'b0;
                check("grant_mem_r_en", 32'(mem_r_en), m_err ? 32'd0 : 32'd1);
                check("grant_mem_addr", 32'(mem_addr), m_err ? 32'd0 : 32'(a));
            end else begin
                check("idle_mem_r_en", 32'(mem_r_en), 32'd0);
                check("idle_mem_addr", 32'(mem_addr), 32'd0);
            end
        end else begin
            check("busy_req_ready", 32'(req_ready), 32'd0);
            check("busy_mem_r_en", 32'(mem_r_en), 32'd0);
            check("busy_mem_addr", 32'(mem_addr), 32'd0);
            if (cyc >= m_due) begin
                check("rsp_valid", 32'(rsp_valid), 32'd1 << m_port);
                check("rsp_data", 32'(rsp_data), 32'(m_data));
                check("rsp_err", 32'(rsp_err), 32'(m_err));
                if (rdy[m_port]) m_busy = 1'b0;
            end else begin
                check("wait_rsp_valid", 32'(rsp_valid), 32'd0);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        hv[0] = 1'b0; hv[1] = 1'b0;
        ha[0] = '0;   ha[1] = '0;
        rdy = 2'b00; rst = 1'b1; mode = 0;
        m_busy = 1'b0; m_pref = 0; cyc = 0;

        run(2);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;

        // single fetch read of address 5
        hv[0] = 1'b1; ha[0] = 16'h0005; rdy = 2'b01;
        run(6);

        // both ports requesting continuously
        mode = 1; rdy = 2'b11;
        run(24);
        mode = 0;
        run(4);
        hv[0] = 1'b0; hv[1] = 1'b0;
        run(4);

        // out-of-range on debug port, plus boundary addresses
        hv[1] = 1'b1; ha[1] = 16'h0100; rdy = 2'b10;
        run(4);
        hv[0] = 1'b1; ha[0] = 16'h00FF; rdy = 2'b01;
        run(4);
        hv[1] = 1'b1; ha[1] = 16'hFFFF; rdy = 2'b10;
        run(4);

        // backpressure then release
        hv[0] = 1'b1; ha[0] = 16'h0033; rdy = 2'b00;
        run(7);
        rdy = 2'b01;
        run(3);

        // reset during WAIT
        hv[0] = 1'b1; ha[0] = 16'h0007; rdy = 2'b01;
        run(1);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(5);

        // non-owner ready must not complete the response
        hv[0] = 1'b1; ha[0] = 16'h0042; rdy = 2'b10;
        run(6);
        rdy = 2'b01;
        run(3);

        // random traffic with occasional resets
        mode = 2;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (rst) begin
                hv[0] = 1'b0;
                hv[1] = 1'b0;
            end
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
